// File: rtl/frame_pkg.sv
// ============================================================
// frame_pkg: mode encodings, step masks and event decode helper
// Rev 1.0
// ============================================================
`default_nettype none

package frame_pkg;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } frame_mode_e;

  localparam int STEP_W = 3;

  localparam logic [STEP_W-1:0] LAST_STEP_4 = 3'd3;
  localparam logic [STEP_W-1:0] LAST_STEP_5 = 3'd4;

  // Bit n of each mask enables the event when the tick lands on step n.
  localparam logic [4:0] Q_MASK_4 = 5'b01111;
  localparam logic [4:0] H_MASK_4 = 5'b01010;
  localparam logic [4:0] I_MASK_4 = 5'b01000;
  localparam logic [4:0] Q_MASK_5 = 5'b10111;
  localparam logic [4:0] H_MASK_5 = 5'b10010;
  localparam logic [4:0] I_MASK_5 = 5'b00000;

  typedef struct packed {
    logic qfr;
    logic hfr;
    logic irq;
  } frame_evt_t;

  function automatic frame_evt_t step_events(frame_mode_e mode, logic [STEP_W-1:0] s);
    logic [4:0] q;
    logic [4:0] h;
    logic [4:0] i;
    frame_evt_t e;
    q = (mode == MODE_5STEP) ? Q_MASK_5 : Q_MASK_4;
    h = (mode == MODE_5STEP) ? H_MASK_5 : H_MASK_4;
    i = (mode == MODE_5STEP) ? I_MASK_5 : I_MASK_4;
    e = '0;
    if (s <= 3'd4) begin
      e.qfr = q[s];
      e.hfr = h[s];
      e.irq = i[s];
    end
    return e;
  endfunction

  function automatic logic [STEP_W-1:0] last_step(frame_mode_e mode);
    return (mode == MODE_5STEP) ? LAST_STEP_5 : LAST_STEP_4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_prescaler.sv
// ============================================================
// frame_prescaler: modulo-PRESCALE counter with sync clear and tick
// Rev 1.0
// ============================================================
`default_nettype none

module frame_prescaler #(
  parameter int PRESCALE = 20,
  parameter int CNT_W    = $clog2(PRESCALE)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  generate
    if (PRESCALE < 2) begin : g_bad_prescale
      $error("frame_prescaler: PRESCALE must be at least 2");
    end
    if (CNT_W < $clog2(PRESCALE)) begin : g_bad_cnt_w
      $error("frame_prescaler: CNT_W too narrow for PRESCALE");
    end
  endgenerate

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == c_last_cnt);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_sequencer.sv
// ============================================================
// frame_sequencer: 4/5-step frame sequencer, event pulses and IRQ
// Rev 1.0
// ============================================================
`default_nettype none

module frame_sequencer
  import frame_pkg::*;
#(
  parameter int CLK_HZ = 4800,
  parameter int QFR_HZ = 240,
  parameter int CNT_W  = $clog2(CLK_HZ / QFR_HZ)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_we,
  input  logic        frame_mode,
  input  logic        frame_irq_inh,
  input  logic        irq_ack,
  output logic        qfr_pulse,
  output logic        hfr_pulse,
  output logic        irq,
  output logic [2:0]  step,
  output logic        qfr_clk,
  output logic        hfr_clk
);

  localparam int PRESCALE = CLK_HZ / QFR_HZ;

  logic        w_tick;
  frame_evt_t  w_evt;

  frame_mode_e       mode_q, mode_d;
  logic              inh_q, inh_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              qfr_q, qfr_d;
  logic              hfr_q, hfr_d;
  logic              irq_q, irq_d;
  logic              qclk_q, qclk_d;
  logic              hclk_q, hclk_d;

  // A write restarts the tick period so the next event lands PRESCALE cycles later.
  frame_prescaler #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (frame_we),
    .tick_o (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_4STEP;
      inh_q  <= 1'b0;
      step_q <= '0;
      qfr_q  <= 1'b0;
      hfr_q  <= 1'b0;
      irq_q  <= 1'b0;
      qclk_q <= 1'b0;
      hclk_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      inh_q  <= inh_d;
      step_q <= step_d;
      qfr_q  <= qfr_d;
      hfr_q  <= hfr_d;
      irq_q  <= irq_d;
      qclk_q <= qclk_d;
      hclk_q <= hclk_d;
    end
  end

  always_comb begin
    w_evt  = step_events(mode_q, step_q);
    mode_d = mode_q;
    inh_d  = inh_q;
    step_d = step_q;
    qfr_d  = 1'b0;
    hfr_d  = 1'b0;
    irq_d  = irq_q & ~irq_ack;

    // The write branch excludes the tick branch, so a coincident tick is dropped.
    if (frame_we) begin
      mode_d = frame_mode_e'(frame_mode);
      inh_d  = frame_irq_inh;
      step_d = '0;
      qfr_d  = (mode_d == MODE_5STEP);
      hfr_d  = (mode_d == MODE_5STEP);
      if (frame_irq_inh) begin
        irq_d = 1'b0;
      end
    end else if (w_tick) begin
      qfr_d = w_evt.qfr;
      hfr_d = w_evt.hfr;
      if (w_evt.irq && !inh_q) begin
        irq_d = 1'b1;
      end
      step_d = (step_q >= last_step(mode_q)) ? '0 : step_q + STEP_W'(1);
    end

    qclk_d = qclk_q ^ qfr_d;
    hclk_d = hclk_q ^ hfr_d;
  end

  always_comb begin
    qfr_pulse = qfr_q;
    hfr_pulse = hfr_q;
    irq       = irq_q;
    step      = step_q;
    qfr_clk   = qclk_q;
    hfr_clk   = hclk_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_sequencer.sv
// ============================================================
// tb_frame_sequencer: directed vector bench for frame_sequencer
// Rev 1.0
// ============================================================
`default_nettype none

module tb_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_we = 1'b0;
  logic       frame_mode = 1'b0;
  logic       frame_irq_inh = 1'b0;
  logic       irq_ack = 1'b0;
  logic       qfr_pulse;
  logic       hfr_pulse;
  logic       irq;
  logic [2:0] step;
  logic       qfr_clk;
  logic       hfr_clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int edge_n = 0;
  int win_q  = 0;
  int win_h  = 0;
  int win_i  = 0;
  bit win_en = 1'b0;

  localparam int N_RST_VECS = 8;

  // exp = {qfr, hfr, irq, step[2:0], qfr_clk, hfr_clk}; in = {we, mode, inh, ack}
  typedef struct {
    string      name;
    int         at;
    logic [3:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  frame_sequencer #(
    .CLK_HZ (4800),
    .QFR_HZ (240)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_we      (frame_we),
    .frame_mode    (frame_mode),
    .frame_irq_inh (frame_irq_inh),
    .irq_ack       (irq_ack),
    .qfr_pulse     (qfr_pulse),
    .hfr_pulse     (hfr_pulse),
    .irq           (irq),
    .step          (step),
    .qfr_clk       (qfr_clk),
    .hfr_clk       (hfr_clk)
  );

  function automatic logic [7:0] obs();
    return {qfr_pulse, hfr_pulse, irq, step, qfr_clk, hfr_clk};
  endfunction

  task automatic add(input string n, input int at, input logic [3:0] in, input logic [7:0] exp);
    vec_t v;
    v.name = n;
    v.at   = at;
    v.in   = in;
    v.exp  = exp;
    vq.push_back(v);
  endtask

  task automatic check(input string n, input logic [7:0] exp);
    logic [7:0] got;
    got = obs();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got q,h,irq,step,qc,hc=%b required %b", n, edge_n, got, exp);
    end
  endtask

  task automatic check_int(input string n, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (win_en && edge_n >= 266 && edge_n <= 365) begin
      if (qfr_pulse) win_q++;
      if (hfr_pulse) win_h++;
      if (irq)       win_i++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    if (v.at <= edge_n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s%s: target edge %0d already passed (%0d)", tag, v.name, v.at, edge_n);
    end else begin
      while (edge_n < v.at - 1) tick();
      {frame_we, frame_mode, frame_irq_inh, irq_ack} = v.in;
      tick();
      {frame_we, frame_mode, frame_irq_inh, irq_ack} = 4'b0000;
      check({tag, v.name}, v.exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    // Mode 0 from reset; first N_RST_VECS entries are replayed after the async reset.
    add("rst_e1",      1,   4'b0000, 8'b000_000_00);
    add("pre_tick",    19,  4'b0000, 8'b000_000_00);
    add("s0_q",        20,  4'b0000, 8'b100_001_10);
    add("s0_end",      21,  4'b0000, 8'b000_001_10);
    add("s1_qh",       40,  4'b0000, 8'b110_010_01);
    add("s2_q",        60,  4'b0000, 8'b100_011_11);
    add("s3_qhi",      80,  4'b0000, 8'b111_000_00);
    add("irq_hold",    81,  4'b0000, 8'b001_000_00);
    // irq_ack coincident with the next set, then a lone ack
    add("s0_m0",       100, 4'b0000, 8'b101_001_10);
    add("ack_set",     160, 4'b0001, 8'b111_000_00);
    add("ack_lone",    165, 4'b0001, 8'b000_000_00);
    // write on the tick cycle drops the tick
    add("we_tick",     180, 4'b1000, 8'b000_000_00);
    add("we_tick_pre", 199, 4'b0000, 8'b000_000_00);
    add("we_tick_q",   200, 4'b0000, 8'b100_001_10);
    add("irq_m0",      260, 4'b0000, 8'b111_000_00);
    // 5-step write with inhibit
    add("we5_imm",     265, 4'b1110, 8'b110_000_11);
    add("we5_end",     266, 4'b0000, 8'b000_000_11);
    add("m5_s0",       285, 4'b0000, 8'b100_001_01);
    add("m5_s1",       305, 4'b0000, 8'b110_010_10);
    add("m5_s2",       325, 4'b0000, 8'b100_011_00);
    add("m5_s3",       345, 4'b0000, 8'b000_100_00);
    add("m5_s4",       365, 4'b0000, 8'b110_000_11);
    // back-to-back 5-step writes
    add("b2b_0",       370, 4'b1110, 8'b110_000_00);
    add("b2b_1",       371, 4'b1110, 8'b110_000_11);
    add("b2b_2",       372, 4'b1110, 8'b110_000_00);
    add("b2b_end",     373, 4'b0000, 8'b000_000_00);
    // write while a pulse is high, then inhibit-write against an IRQ set
    add("we_m0",       380, 4'b1000, 8'b000_000_00);
    add("m0_s0",       400, 4'b0000, 8'b100_001_10);
    add("we_in_pulse", 401, 4'b1000, 8'b000_000_10);
    add("restart_q",   421, 4'b0000, 8'b100_001_00);
    add("pre_inh",     480, 4'b0000, 8'b000_011_01);
    add("inh_wins",    481, 4'b1010, 8'b000_000_01);
    add("inh_next",    501, 4'b0000, 8'b100_001_11);
    add("inh_s3",      561, 4'b0000, 8'b110_000_01);
    add("pre_rst",     610, 4'b0000, 8'b000_010_00);

    #2 rst_n = 1'b0;
    #1;
    check("reset_assert", 8'b000_000_00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 8'b000_000_00);
    rst_n  = 1'b1;
    edge_n = 0;
    win_en = 1'b1;

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], "");

    check_int("win_qfr_count", win_q, 4);
    check_int("win_hfr_count", win_h, 2);
    check_int("win_irq_cycles", win_i, 0);
    win_en = 1'b0;

    // async reset mid-sequence at step 2
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 8'b000_000_00);
    @(posedge clk);
    #1;
    check("async_rst_hold", 8'b000_000_00);
    rst_n  = 1'b1;
    edge_n = 0;

    for (int i = 0; i < N_RST_VECS; i++) run_vec(vq[i], "rerun_");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
